// File: rtl/mac_job_ctrl.sv
// Job sequencer for the MAC streaming accelerator: one shadow descriptor slot feeding a start/run/drain FSM.
// Latency: a descriptor written at edge N is popped at edge N+1; ap_start rises one cycle after CFG.
// Backpressure: job_ready_o is low while the shadow slot is full; d-stream beats are only monitored, never stalled.
//
// Ports:
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   job_valid_i/job_ready_o         descriptor handshake; job_len_i, job_simple_mul_i, job_shift_i carry the payload
//   abort_i                         pulse that abandons the active job (CFG..DRAIN)
//   mac_start_o, mac_done_i,        ap_start / ap_done / ap_idle / ap_ready of the MAC
//   mac_idle_i, mac_ready_i
//   naive_mul_V_o, new_shift_V_o    MAC configuration, reloaded at every CFG
//   d_tvalid_i, d_tready_i          monitored MAC output stream, one beat per valid&ready
//   busy_o                          sequencer not idle
//   evt_done_o, evt_abort_o         one-cycle event pulses for the host
//   beats_o, jobs_done_o            beats seen in the current job, completed-job counter

module mac_job_ctrl #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [LEN_WIDTH-1:0] job_len_i,
  input  logic                 job_simple_mul_i,
  input  logic                 job_shift_i,
  input  logic                 abort_i,
  output logic                 mac_start_o,
  input  logic                 mac_done_i,
  input  logic                 mac_idle_i,
  input  logic                 mac_ready_i,
  output logic                 naive_mul_V_o,
  output logic                 new_shift_V_o,
  input  logic                 d_tvalid_i,
  input  logic                 d_tready_i,
  output logic                 busy_o,
  output logic                 evt_done_o,
  output logic                 evt_abort_o,
  output logic [LEN_WIDTH-1:0] beats_o,
  output logic [CNT_WIDTH-1:0] jobs_done_o
);

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic                 simple_mul;
    logic                 shift;
  } job_desc_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  state_t               state_q, state_d;
  job_desc_t            pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [LEN_WIDTH-1:0] act_len_q, act_len_d;
  logic                 mul_q, mul_d;
  logic                 shift_q, shift_d;
  logic [LEN_WIDTH-1:0] beats_q, beats_d;
  logic [CNT_WIDTH-1:0] jobs_q, jobs_d;
  logic                 done_seen_q, done_seen_d;
  logic                 evt_abort_q, evt_abort_d;

  job_desc_t            job_in;
  logic                 push;
  logic                 beat;
  logic [LEN_WIDTH-1:0] beats_inc;
  logic [CNT_WIDTH-1:0] jobs_inc;

  assign job_in.len        = job_len_i;
  assign job_in.simple_mul = job_simple_mul_i;
  assign job_in.shift      = job_shift_i;

  // The slot only accepts when empty and the FSM only pops when full, so a
  // push and a pop can never land in the same cycle.
  assign push      = job_valid_i & ~pend_vld_q;
  assign beat      = d_tvalid_i & d_tready_i;
  assign beats_inc = beats_q + LEN_WIDTH'(1);
  assign jobs_inc  = jobs_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    act_len_d   = act_len_q;
    mul_d       = mul_q;
    shift_d     = shift_q;
    beats_d     = beats_q;
    jobs_d      = jobs_q;
    done_seen_d = done_seen_q;
    evt_abort_d = 1'b0;

    if (push) begin
      pend_d     = job_in;
      pend_vld_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // Registered slot only: a descriptor written this cycle is seen next cycle.
        if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          act_len_d  = pend_q.len;
          if (pend_q.len == '0) begin
            // Empty job completes without touching the MAC or its config.
            state_d = S_FIN;
            jobs_d  = jobs_inc;
          end else begin
            state_d     = S_CFG;
            mul_d       = pend_q.simple_mul;
            shift_d     = pend_q.shift;
            beats_d     = '0;
            done_seen_d = 1'b0;
          end
        end
      end
      S_CFG: begin
        state_d = abort_i ? S_ABORT : S_START;
      end
      S_START: begin
        if (abort_i) begin
          state_d = S_ABORT;
        end else if (mac_ready_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over both a completing beat and ap_done.
        if (abort_i) begin
          state_d = S_ABORT;
        end else begin
          if (mac_done_i) begin
            done_seen_d = 1'b1;
          end
          if (beat) begin
            beats_d = beats_inc;
            if (beats_inc == act_len_q) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        // Beats arriving here are past the job length and are not counted.
        if (abort_i) begin
          state_d = S_ABORT;
        end else if (done_seen_q | mac_done_i | mac_idle_i) begin
          state_d = S_FIN;
          jobs_d  = jobs_inc;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (mac_idle_i) begin
          state_d     = S_IDLE;
          evt_abort_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      act_len_q   <= '0;
      mul_q       <= 1'b0;
      shift_q     <= 1'b0;
      beats_q     <= '0;
      jobs_q      <= '0;
      done_seen_q <= 1'b0;
      evt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      act_len_q   <= act_len_d;
      mul_q       <= mul_d;
      shift_q     <= shift_d;
      beats_q     <= beats_d;
      jobs_q      <= jobs_d;
      done_seen_q <= done_seen_d;
      evt_abort_q <= evt_abort_d;
    end
  end

  // ap_start is a pure decode of the START state, so it falls the cycle after
  // ap_ready, an abort, or a reset is sampled.
  assign job_ready_o   = ~pend_vld_q;
  assign mac_start_o   = (state_q == S_START);
  assign busy_o        = (state_q != S_IDLE);
  assign evt_done_o    = (state_q == S_FIN);
  assign evt_abort_o   = evt_abort_q;
  assign naive_mul_V_o = mul_q;
  assign new_shift_V_o = shift_q;
  assign beats_o       = beats_q;
  assign jobs_done_o   = jobs_q;

endmodule

// File: tb/tb_mac_job_ctrl.sv
`timescale 1ns/1ps
module tb_mac_job_ctrl;

  localparam int LW = 16;
  localparam int CW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  logic [LW-1:0] job_len_i = '0;
  logic          job_simple_mul_i = 1'b0;
  logic          job_shift_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          mac_start_o;
  logic          mac_done_i = 1'b0;
  logic          mac_idle_i = 1'b0;
  logic          mac_ready_i = 1'b0;
  logic          naive_mul_V_o;
  logic          new_shift_V_o;
  logic          d_tvalid_i = 1'b0;
  logic          d_tready_i = 1'b0;
  logic          busy_o;
  logic          evt_done_o;
  logic          evt_abort_o;
  logic [LW-1:0] beats_o;
  logic [CW-1:0] jobs_done_o;

  always #5 ap_clk = ~ap_clk;

  mac_job_ctrl #(.LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_len_i(job_len_i), .job_simple_mul_i(job_simple_mul_i), .job_shift_i(job_shift_i),
    .abort_i(abort_i),
    .mac_start_o(mac_start_o), .mac_done_i(mac_done_i), .mac_idle_i(mac_idle_i), .mac_ready_i(mac_ready_i),
    .naive_mul_V_o(naive_mul_V_o), .new_shift_V_o(new_shift_V_o),
    .d_tvalid_i(d_tvalid_i), .d_tready_i(d_tready_i),
    .busy_o(busy_o), .evt_done_o(evt_done_o), .evt_abort_o(evt_abort_o),
    .beats_o(beats_o), .jobs_done_o(jobs_done_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one job at a time, as a timeline ----------------
  typedef struct {
    int len;
    bit mul;
    bit shift;
  } desc_t;

  desc_t slot[$];
  bit e_start, e_busy, e_done, e_abort, e_mul, e_shift;
  int e_beats, e_jobs;
  bit s_full, s_rst, s_abort, s_ready, s_done, s_idle, s_beat;
  bit chk_en = 1'b0;

  // Advance the model by one clock edge: sample inputs, clear pulses, track the slot.
  task automatic tick();
    desc_t d;
    @(posedge ap_clk);
    s_full  = (slot.size() != 0);
    s_rst   = ap_rst;
    s_abort = abort_i;
    s_ready = mac_ready_i;
    s_done  = mac_done_i;
    s_idle  = mac_idle_i;
    s_beat  = d_tvalid_i && d_tready_i;
    e_done  = 0;
    e_abort = 0;
    if (s_rst) begin
      slot.delete();
      e_start = 0; e_busy = 0; e_beats = 0; e_jobs = 0; e_mul = 0; e_shift = 0;
    end else if (job_valid_i && !s_full) begin
      d.len = int'(job_len_i); d.mul = job_simple_mul_i; d.shift = job_shift_i;
      slot.push_back(d);
    end
  endtask

  task automatic model_abort();
    e_start = 0;
    forever begin
      tick(); if (s_rst) return;
      if (s_idle) break;
    end
    e_abort = 1;
    e_busy  = 0;
  endtask

  task automatic model_job();
    desc_t d;
    bit seen;
    forever begin
      tick(); if (s_rst) return;
      if (s_full) break;
    end
    d = slot.pop_front();
    e_busy = 1;
    if (d.len == 0) begin
      e_done = 1; e_jobs = (e_jobs + 1) % 65536;
      tick(); if (s_rst) return;
      e_busy = 0;
      return;
    end
    e_mul = d.mul; e_shift = d.shift; e_beats = 0;
    tick(); if (s_rst) return;
    if (s_abort) begin model_abort(); return; end
    e_start = 1;
    forever begin
      tick(); if (s_rst) return;
      if (s_abort) begin model_abort(); return; end
      if (s_ready) break;
    end
    e_start = 0;
    seen = 0;
    while (e_beats < d.len) begin
      tick(); if (s_rst) return;
      if (s_abort) begin model_abort(); return; end
      if (s_done) seen = 1;
      if (s_beat) e_beats++;
    end
    forever begin
      tick(); if (s_rst) return;
      if (s_abort) begin model_abort(); return; end
      if (seen || s_done || s_idle) break;
    end
    e_done = 1; e_jobs = (e_jobs + 1) % 65536;
    tick(); if (s_rst) return;
    e_busy = 0;
  endtask

  initial begin
    e_start = 0; e_busy = 0; e_done = 0; e_abort = 0; e_mul = 0; e_shift = 0;
    e_beats = 0; e_jobs = 0;
    forever model_job();
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      check("job_ready",   32'(job_ready_o),   32'(slot.size() == 0));
      check("mac_start",   32'(mac_start_o),   32'(e_start));
      check("busy",        32'(busy_o),        32'(e_busy));
      check("evt_done",    32'(evt_done_o),    32'(e_done));
      check("evt_abort",   32'(evt_abort_o),   32'(e_abort));
      check("naive_mul",   32'(naive_mul_V_o), 32'(e_mul));
      check("new_shift",   32'(new_shift_V_o), 32'(e_shift));
      check("beats",       32'(beats_o),       e_beats);
      check("jobs_done",   32'(jobs_done_o),   e_jobs);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus helpers (all start and end on a falling edge) ----------------
  task automatic cyc();
    @(negedge ap_clk);
  endtask

  task automatic push(input int len, input bit mul, input bit sh);
    int n = 0;
    while (!job_ready_o && n < 100) begin cyc(); n++; end
    check("push_ready", 32'(job_ready_o), 1);
    job_valid_i = 1'b1; job_len_i = LW'(len); job_simple_mul_i = mul; job_shift_i = sh;
    cyc();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mac_start_o && n < 50) begin cyc(); n++; end
    check("start_seen", 32'(mac_start_o), 1);
  endtask

  task automatic mac_handshake(input int delay);
    wait_start();
    repeat (delay) cyc();
    mac_ready_i = 1'b1; cyc(); mac_ready_i = 1'b0;
  endtask

  task automatic send_beats(input int n_hs, input bit toggle, input int extra);
    int sent = 0;
    bit ph = 1'b1;
    while (sent < n_hs + extra) begin
      d_tvalid_i = 1'b1;
      d_tready_i = toggle ? ph : 1'b1;
      if (d_tready_i) sent++;
      ph = !ph;
      cyc();
    end
    d_tvalid_i = 1'b0; d_tready_i = 1'b0;
  endtask

  task automatic pulse_done();
    mac_done_i = 1'b1; cyc(); mac_done_i = 1'b0;
  endtask

  task automatic wait_evt_done();
    int n = 0;
    while (!evt_done_o && n < 50) begin cyc(); n++; end
    check("evt_done_seen", 32'(evt_done_o), 1);
  endtask

  task automatic wait_evt_abort();
    int n = 0;
    while (!evt_abort_o && n < 50) begin cyc(); n++; end
    check("evt_abort_seen", 32'(evt_abort_o), 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    chk_en = 1'b1;
    check("rst_job_ready", 32'(job_ready_o), 1);
    check("rst_busy",      32'(busy_o), 0);
    check("rst_start",     32'(mac_start_o), 0);
    check("rst_jobs",      32'(jobs_done_o), 0);

    // Single job len=4, simple_mul=1, shift=0
    push(4, 1'b1, 1'b0);
    mac_handshake(2);
    check("s1_start_dropped", 32'(mac_start_o), 0);
    check("s1_naive",         32'(naive_mul_V_o), 1);
    send_beats(4, 1'b0, 0);
    pulse_done();
    wait_evt_done();
    check("s1_jobs",  32'(jobs_done_o), 1);
    check("s1_beats", 32'(beats_o), 4);
    cyc();
    check("s1_single_pulse", 32'(evt_done_o), 0);

    // Backpressure: len=3, tready toggling, one surplus beat in DRAIN
    push(3, 1'b0, 1'b0);
    mac_handshake(0);
    send_beats(3, 1'b1, 1);
    check("s2_beats_saturated", 32'(beats_o), 3);
    pulse_done();
    wait_evt_done();
    check("s2_jobs",  32'(jobs_done_o), 2);
    check("s2_naive", 32'(naive_mul_V_o), 0);

    // Queueing: A (len=2) then B (len=5, mul=1, shift=1)
    push(2, 1'b0, 1'b0);
    push(5, 1'b1, 1'b1);
    check("s3_ready_low", 32'(job_ready_o), 0);
    check("s3_busy",      32'(busy_o), 1);
    mac_handshake(1);
    check("s3_shift_a", 32'(new_shift_V_o), 0);
    send_beats(1, 1'b0, 0);
    pulse_done();                 // ap_done during RUN, must be remembered
    send_beats(1, 1'b0, 0);
    wait_evt_done();
    check("s3_jobs_a",  32'(jobs_done_o), 3);
    check("s3_beats_a", 32'(beats_o), 2);
    mac_handshake(0);
    check("s3_shift_b", 32'(new_shift_V_o), 1);
    check("s3_naive_b", 32'(naive_mul_V_o), 1);
    send_beats(5, 1'b0, 0);
    mac_idle_i = 1'b1; cyc(); mac_idle_i = 1'b0;
    wait_evt_done();
    check("s3_jobs_b",  32'(jobs_done_o), 4);

    // len=0 job: never starts the MAC, config untouched
    push(0, 1'b0, 1'b0);
    check("s4_no_done_yet", 32'(evt_done_o), 0);
    cyc();
    check("s4_done_2cyc",   32'(evt_done_o), 1);
    check("s4_jobs",        32'(jobs_done_o), 5);
    check("s4_naive_kept",  32'(naive_mul_V_o), 1);
    check("s4_shift_kept",  32'(new_shift_V_o), 1);
    check("s4_beats_kept",  32'(beats_o), 5);
    repeat (2) cyc();

    // Abort in RUN after 2 of 8 beats, with job D queued behind
    push(8, 1'b0, 1'b1);
    push(1, 1'b1, 1'b0);
    mac_handshake(0);
    send_beats(2, 1'b0, 0);
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    check("s5_start_low",  32'(mac_start_o), 0);
    check("s5_busy",       32'(busy_o), 1);
    check("s5_beats",      32'(beats_o), 2);
    repeat (2) cyc();
    check("s5_wait_idle",  32'(evt_abort_o), 0);
    mac_idle_i = 1'b1; cyc(); mac_idle_i = 1'b0;
    wait_evt_abort();
    check("s5_jobs_kept",  32'(jobs_done_o), 5);
    mac_handshake(0);
    check("s5_naive_d",    32'(naive_mul_V_o), 1);
    check("s5_shift_d",    32'(new_shift_V_o), 0);
    send_beats(1, 1'b0, 0);
    pulse_done();
    wait_evt_done();
    check("s5_jobs_d",     32'(jobs_done_o), 6);

    // Reset in START with a pending descriptor
    push(3, 1'b1, 1'b1);
    push(2, 1'b0, 1'b0);
    wait_start();
    ap_rst = 1'b1; cyc(); ap_rst = 1'b0;
    check("s6_ready", 32'(job_ready_o), 1);
    check("s6_busy",  32'(busy_o), 0);
    check("s6_start", 32'(mac_start_o), 0);
    check("s6_jobs",  32'(jobs_done_o), 0);
    check("s6_naive", 32'(naive_mul_V_o), 0);
    check("s6_shift", 32'(new_shift_V_o), 0);
    check("s6_beats", 32'(beats_o), 0);
    repeat (5) cyc();
    check("s6_queue_lost", 32'(busy_o), 0);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
